// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: multi-digit decimal event counter with a time-multiplexed
// digit scan. It feeds a BCD-to-7-segment decoder one digit at a time. Blanked
// digits are driven as 4'hF, which the decoder renders as all segments off.
module bcd_scan_counter #(
    parameter int NDIG     = 4,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK    = 0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic                INC,
    input  logic                CLR,
    output logic [4*NDIG-1:0]   BCD,
    output logic                OVF,
    output logic [3:0]          D,
    output logic [NDIG-1:0]     AN
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [4*NDIG-1:0] bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [3:0]        d_q, d_d;
    logic [NDIG-1:0]   an_q, an_d;

    // carry[k] is high when digits 0..k-1 are all 9, so digit k must step.
    logic [NDIG:0]     carry;
    logic [4*NDIG-1:0] bcd_inc;
    // zero_from[k] is high when digits k..NDIG-1 are all zero.
    logic [NDIG:1]     zero_from;

    assign carry[0]        = 1'b1;
    assign zero_from[NDIG] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_digit
            logic [3:0] dig;
            assign dig              = bcd_q[4*gi +: 4];
            assign carry[gi+1]      = carry[gi] & (dig == 4'd9);
            assign bcd_inc[4*gi +: 4] = !carry[gi] ? dig :
                                        ((dig == 4'd9) ? 4'd0 : dig + 4'd1);
        end
        for (gi = 1; gi < NDIG; gi++) begin : g_zero
            assign zero_from[gi] = zero_from[gi+1] & (bcd_q[4*gi +: 4] == 4'd0);
        end
    endgenerate

    // Count next state: clear beats increment; overflow is the carry out of the top digit.
    always_comb begin
        bcd_d = bcd_q;
        ovf_d = 1'b0;
        if (CLR) begin
            bcd_d = '0;
        end else if (EN && INC) begin
            bcd_d = bcd_inc;
            ovf_d = carry[NDIG];
        end
    end

    // Scan next state: prescaler slot timing, digit index, and the digit/select pair
    // built from the current registered count and index so D and AN always match.
    always_comb begin
        logic [3:0] digit_sel;
        logic       blank_sel;
        presc_d   = presc_q + 1'b1;
        idx_d     = idx_q;
        digit_sel = 4'd0;
        blank_sel = 1'b0;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
        end
        for (int k = 0; k < NDIG; k++) begin
            if (idx_q == IW'(k)) begin
                digit_sel = bcd_q[4*k +: 4];
            end
        end
        // Digit 0 is never blanked, so the search starts at 1.
        for (int k = 1; k < NDIG; k++) begin
            if (idx_q == IW'(k)) begin
                blank_sel = zero_from[k];
            end
        end
        an_d = ~(NDIG'(1) << idx_q);
        d_d  = ((BLANK != 0) && blank_sel) ? 4'hF : digit_sel;
    end

    // State registers; reset restarts the scan at digit 0 with all selects off.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
            d_q     <= 4'h0;
            an_q    <= '1;
        end else begin
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            d_q     <= d_d;
            an_q    <= an_d;
        end
    end

    assign BCD = bcd_q;
    assign OVF = ovf_q;
    assign D   = d_q;
    assign AN  = an_q;

endmodule
